// File: rtl/nor_pack.sv
// Packs a normalized sign/significand/exponent triple into an IEEE half-precision
// word, buffering results in a 2-entry FIFO and counting overflow/underflow events.
module nor_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [10:0]      norm_sum_in,
  input  logic [6:0]       exp_final_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      fp_out,
  output logic             ov_out,
  output logic             uf_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ov_cnt,
  output logic [CNT_W-1:0] uf_cnt
);

  localparam int ENT_W = 18;  // {ov, uf, fp[15:0]}

  logic [ENT_W-1:0] mem_reg [2];
  logic [1:0]       count_reg;
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [CNT_W-1:0] ov_cnt_reg;
  logic [CNT_W-1:0] uf_cnt_reg;

  logic             push;
  logic             pop;
  logic             is_zero;
  logic             is_ov;
  logic             is_uf;
  logic [15:0]      pack_fp;

  // in_ready depends only on occupancy, so a full FIFO refuses input even while popping.
  assign in_ready  = rst && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    is_zero = !norm_sum_in[10];
    is_ov   = !is_zero && (exp_final_in >= 7'd31);
    is_uf   = !is_zero && !is_ov && (exp_final_in == 7'd0);
    pack_fp = {sign_in, exp_final_in[4:0], norm_sum_in[9:0]};
    if (is_zero || is_uf) begin
      pack_fp = {sign_in, 15'h0000};
    end else if (is_ov) begin
      pack_fp = {sign_in, 5'h1F, 10'h000};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= {is_ov, is_uf, pack_fp};
        wr_ptr_reg          <= !wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Events are counted at acceptance; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      ov_cnt_reg <= '0;
      uf_cnt_reg <= '0;
    end else begin
      if (push && is_ov && (ov_cnt_reg != {CNT_W{1'b1}})) begin
        ov_cnt_reg <= ov_cnt_reg + CNT_W'(1);
      end
      if (push && is_uf && (uf_cnt_reg != {CNT_W{1'b1}})) begin
        uf_cnt_reg <= uf_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign {ov_out, uf_out, fp_out} = mem_reg[rd_ptr_reg];
  assign ov_cnt = ov_cnt_reg;
  assign uf_cnt = uf_cnt_reg;

endmodule

// File: tb/tb_nor_pack.sv
// Directed-vector bench for nor_pack; counters built narrow (CNT_W=2) to reach saturation.
module tb_nor_pack;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sign_in;
  logic [10:0]   norm_sum_in;
  logic [6:0]    exp_final_in;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   fp_out;
  logic          ov_out;
  logic          uf_out;
  logic          cnt_clr;
  logic [CW-1:0] ov_cnt;
  logic [CW-1:0] uf_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  nor_pack #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_in      (sign_in),
    .norm_sum_in  (norm_sum_in),
    .exp_final_in (exp_final_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fp_out       (fp_out),
    .ov_out       (ov_out),
    .uf_out       (uf_out),
    .cnt_clr      (cnt_clr),
    .ov_cnt       (ov_cnt),
    .uf_cnt       (uf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [10:0] n, input logic [6:0] e);
    in_valid     = 1'b1;
    sign_in      = s;
    norm_sum_in  = n;
    exp_final_in = e;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    sign_in = 1'b0; norm_sum_in = '0; exp_final_in = '0;
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0 || fp_out !== 16'h0 || ov_out !== 1'b0 || uf_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b fp=%h ov=%b uf=%b, want 0 0000 0 0", out_valid, fp_out, ov_out, uf_out);
    end
    n_cmp++;
    if (ov_cnt !== '0 || uf_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: got ov_cnt=%0d uf_cnt=%0d, want 0 0", ov_cnt, uf_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, want 0", in_ready);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    $display("reset: in_ready=%b out_valid=%b ov_cnt=%0d uf_cnt=%0d", in_ready, out_valid, ov_cnt, uf_cnt);
  endtask

  task automatic test_normal();
    set_in(1'b0, 11'h600, 7'd15);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || fp_out !== 16'h3E00 || ov_out !== 1'b0 || uf_out !== 1'b0) begin
      n_bad++;
      $display("FAIL normal: got valid=%b fp=%h ov=%b uf=%b, want 1 3e00 0 0", out_valid, fp_out, ov_out, uf_out);
    end
    $display("normal: fp_out=%h", fp_out);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL normal_pop: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    set_in(1'b1, 11'h400, 7'd40);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (fp_out !== 16'hFC00 || ov_out !== 1'b1 || uf_out !== 1'b0 || ov_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL overflow: got fp=%h ov=%b uf=%b ov_cnt=%0d, want fc00 1 0 1", fp_out, ov_out, uf_out, ov_cnt);
    end
    $display("overflow: fp_out=%h ov_cnt=%0d", fp_out, ov_cnt);
    // Four more overflows streamed with the consumer always ready: 5 total saturates at 3.
    out_ready = 1'b1;
    set_in(1'b0, 11'h5AA, 7'd127);
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (ov_cnt !== 2'd3 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ov_saturate: got ov_cnt=%0d out_valid=%b, want 3 0", ov_cnt, out_valid);
    end
    $display("saturate: ov_cnt=%0d", ov_cnt);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++;
    if (ov_cnt !== 2'd0 || uf_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL cnt_clr: got ov_cnt=%0d uf_cnt=%0d, want 0 0", ov_cnt, uf_cnt);
    end
  endtask

  task automatic test_pack_rules();
    // {sign, norm, exp, fp, ov, uf, ov_cnt_after, uf_cnt_after}
    logic        v_s   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [10:0] v_n   [7] = '{11'h000, 11'h3FF, 11'h400, 11'h400, 11'h7FF, 11'h400, 11'h400};
    logic [6:0]  v_e   [7] = '{7'd50, 7'd20, 7'd0, 7'd31, 7'd30, 7'd1, 7'd0};
    logic [15:0] v_fp  [7] = '{16'h0000, 16'h8000, 16'h0000, 16'h7C00, 16'h7BFF, 16'h0400, 16'h8000};
    logic        v_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        v_uf  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  v_oc  [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [1:0]  v_uc  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 7; i++) begin
      set_in(v_s[i], v_n[i], v_e[i]);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || fp_out !== v_fp[i] || ov_out !== v_ov[i] || uf_out !== v_uf[i]
          || ov_cnt !== v_oc[i] || uf_cnt !== v_uc[i]) begin
        n_bad++;
        $display("FAIL pack_%0d: got fp=%h ov=%b uf=%b cnts=%0d/%0d, want %h %b %b %0d/%0d",
                 i, fp_out, ov_out, uf_out, ov_cnt, uf_cnt, v_fp[i], v_ov[i], v_uf[i], v_oc[i], v_uc[i]);
      end
      $display("pack %0d: norm=%h exp=%0d -> fp=%h ov=%b uf=%b", i, v_n[i], v_e[i], fp_out, ov_out, uf_out);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_in(1'b0, 11'h600, 7'd15);
    tick();
    set_in(1'b1, 11'h401, 7'd16);
    tick();
    set_in(1'b0, 11'h7FF, 7'd17);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_in_ready: got %b, want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || fp_out !== 16'h3E00) begin
      n_bad++;
      $display("FAIL hold_head: got valid=%b fp=%h, want 1 3e00", out_valid, fp_out);
    end
    $display("backpressure: head fp_out=%h held", fp_out);
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || fp_out !== 16'hC001) begin
      n_bad++;
      $display("FAIL order_second: got valid=%b fp=%h, want 1 c001", out_valid, fp_out);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL third_dropped: got out_valid=%b fp=%h, want 0", out_valid, fp_out);
    end
    $display("backpressure: drained, out_valid=%b", out_valid);
  endtask

  task automatic test_concurrency();
    set_in(1'b0, 11'h600, 7'd15);
    tick();
    set_in(1'b1, 11'h401, 7'd16);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || fp_out !== 16'hC001) begin
      n_bad++;
      $display("FAIL push_pop: got valid=%b in_ready=%b fp=%h, want 1 1 c001", out_valid, in_ready, fp_out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL push_pop_count: got out_valid=%b after one pop, want 0", out_valid);
    end
    $display("concurrency: push+pop kept count at 1");
    // ov_cnt is 1 from the pack-rule vectors; clear must beat this overflow increment.
    set_in(1'b0, 11'h400, 7'd33);
    cnt_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    n_cmp++;
    if (ov_cnt !== 2'd0 || uf_cnt !== 2'd0 || ov_out !== 1'b1 || fp_out !== 16'h7C00) begin
      n_bad++;
      $display("FAIL clr_vs_inc: got ov_cnt=%0d uf_cnt=%0d ov=%b fp=%h, want 0 0 1 7c00", ov_cnt, uf_cnt, ov_out, fp_out);
    end
    $display("concurrency: clr with overflow -> ov_cnt=%0d", ov_cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 11'h400, 7'd60);
    tick();
    set_in(1'b0, 11'h400, 7'd0);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || ov_cnt !== 2'd1 || uf_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL pre_reset_full: got in_ready=%b cnts=%0d/%0d, want 0 1/1", in_ready, ov_cnt, uf_cnt);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || ov_cnt !== 2'd0 || uf_cnt !== 2'd0 || fp_out !== 16'h0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b cnts=%0d/%0d fp=%h in_ready=%b, want 0 0/0 0000 0",
               out_valid, ov_cnt, uf_cnt, fp_out, in_ready);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || fp_out !== 16'h0 || ov_out !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stale_after_reset: got valid=%b fp=%h ov=%b in_ready=%b, want 0 0000 0 1",
               out_valid, fp_out, ov_out, in_ready);
    end
    set_in(1'b0, 11'h7FF, 7'd30);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || fp_out !== 16'h7BFF || ov_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fresh_after_reset: got valid=%b fp=%h ov=%b, want 1 7bff 0", out_valid, fp_out, ov_out);
    end
    $display("reset mid-op: fresh fp_out=%h", fp_out);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_pack_rules();
    test_back_to_back();
    test_concurrency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_pack.md
NOR_PACK -- requirements
Module: nor_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the overflow and underflow event counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  upstream presents a normalized result this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-006 SHALL have port sign_in  input  1  result sign.
REQ-007 SHALL have port norm_sum_in  input  11  normalized significand; bit 10 is the hidden one, bits 9:0 are the fraction.
REQ-008 SHALL have port exp_final_in  input  7  unsigned exponent, biased by 15.
REQ-009 SHALL have port out_valid  output  1  packed result available.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have port fp_out  output  16  packed half-precision word {sign, exp[4:0], frac[9:0]}.
REQ-012 SHALL have port ov_out  output  1  result at fp_out overflowed.
REQ-013 SHALL have port uf_out  output  1  result at fp_out underflowed.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of both event counters.
REQ-015 SHALL have port ov_cnt  output  CNT_W  number of accepted overflow results.
REQ-016 SHALL have port uf_cnt  output  CNT_W  number of accepted underflow results.

Function
REQ-017 SHALL accept an input when in_valid and in_ready are both 1 in the same cycle.
REQ-018 SHALL buffer packed results in a 2-entry FIFO and drive in_ready = 1 whenever fewer than 2 entries are held, including a cycle in which an entry is popped.
REQ-019 SHALL drive out_valid = 1 whenever the FIFO holds at least one entry, and SHALL present the oldest entry on fp_out, ov_out and uf_out.
REQ-020 SHALL pop the head entry when out_valid and out_ready are both 1.
REQ-021 SHALL make an accepted input visible at the outputs 1 cycle later when the FIFO was empty.
REQ-022 SHALL keep the entry count unchanged on a simultaneous accept and pop, and SHALL preserve FIFO order.
REQ-023 SHALL hold fp_out, ov_out and uf_out stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL pack each result using the first matching rule, in the order given in REQ-025 to REQ-028.
REQ-025 Zero: SHALL pack {sign_in, 15'h0000} with ov_out = 0 and uf_out = 0 when norm_sum_in[10] = 0.
REQ-026 Overflow: SHALL pack {sign_in, 5'h1F, 10'h000} with ov_out = 1 when exp_final_in >= 31.
REQ-027 Underflow: SHALL pack {sign_in, 15'h0000} with uf_out = 1 when exp_final_in = 0; subnormals are not produced.
REQ-028 Normal: SHALL pack {sign_in, exp_final_in[4:0], norm_sum_in[9:0]} with both flags 0.
REQ-029 SHALL increment ov_cnt or uf_cnt when an overflow or underflow input is accepted (not when it is output), and SHALL saturate each counter at 2^CNT_W-1.
REQ-030 SHALL set both counters to 0 when cnt_clr = 1, and clear SHALL take precedence over an increment in the same cycle.
REQ-031 SHALL ignore all input fields while in_valid = 0 or in_ready = 0.

Reset
REQ-032 SHALL, while rst = 0 at a clock edge, empty the FIFO and drive out_valid = 0, fp_out = 0, ov_out = 0, uf_out = 0, ov_cnt = 0 and uf_cnt = 0.
REQ-033 SHALL drive in_ready = 0 during reset and 1 in the first cycle after rst returns to 1.
REQ-034 SHALL discard any buffered or in-flight result when reset is asserted mid-operation, and no discarded result SHALL appear after reset.

Verification
REQ-035 Normal: sign=0, norm_sum=11'h600, exp=15 accepted with FIFO empty -> next cycle out_valid=1 and fp_out=16'h3E00, flags 0.
REQ-036 Overflow and saturation: exp=40, sign=1 accepted -> fp_out=16'hFC00 and ov_out=1; with CNT_W=2, five overflow inputs -> ov_cnt=3.
REQ-037 Priority: norm_sum=11'h000 with exp=50 -> fp_out=16'h0000 and ov_cnt unchanged; norm_sum=11'h400 with exp=0 -> fp_out=16'h0000, uf_out=1 and uf_cnt+1.
REQ-038 Backpressure: out_ready=0 and three back-to-back valid inputs -> first two held, in_ready=0 on the third cycle, and after release outputs appear in order with none lost.
REQ-039 Concurrency: simultaneous accept and pop at 1 entry -> count stays 1; cnt_clr in the same cycle as an overflow accept -> ov_cnt=0.
REQ-040 Reset mid-operation: rst=0 with 2 entries buffered -> out_valid=0 and counters 0 next cycle, and no stale output after release.
